// File: rtl/can_tx_arbiter.sv
// rtl/can_tx_arbiter.sv - lowest-ID arbiter sharing one CAN transmitter among N requesters
module can_tx_arbiter #(
    parameter int N         = 4,
    parameter int FW        = 108,
    parameter int ID_MSB    = 107,
    parameter int TIMEOUT   = 20000,
    parameter int MAX_RETRY = 2
) (
    input  logic            gclk_i,
    input  logic            res_i,
    input  logic [N-1:0]    req_i,
    input  logic [N*FW-1:0] req_frame_i,
    output logic [N-1:0]    grant_o,
    output logic [N-1:0]    done_o,
    output logic [N-1:0]    err_o,
    output logic            busy_o,
    output logic [FW-1:0]   can_din_o,
    output logic            can_tx_start_o,
    input  logic            can_tx_ready_i
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_RETRY, S_FINISH
    } state_t;

    state_t          state_q;
    logic [N-1:0]    grant_q;
    logic [N-1:0]    done_q;
    logic [N-1:0]    err_q;
    logic            busy_q;
    logic [FW-1:0]   din_q;
    logic            start_q;
    logic [TW-1:0]   timer_q;
    logic [RW-1:0]   retry_q;

    logic            win_valid;
    logic [10:0]     win_id;
    logic [10:0]     cur_id;
    logic [FW-1:0]   win_frame;
    logic [N-1:0]    win_onehot;
    logic [TW-1:0]   timer_d;
    logic            timed_out;

    // Strict less-than keeps the lowest index on an ID tie.
    always_comb begin
        win_valid  = 1'b0;
        win_id     = '1;
        cur_id     = '0;
        win_frame  = '0;
        win_onehot = '0;
        for (int i = 0; i < N; i++) begin
            cur_id = req_frame_i[i*FW + ID_MSB -: 11];
            if (req_i[i] && (!win_valid || cur_id < win_id)) begin
                win_valid  = 1'b1;
                win_id     = cur_id;
                win_frame  = req_frame_i[i*FW +: FW];
                win_onehot = N'(1) << i;
            end
        end
    end

    always_comb begin
        timer_d   = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
        timed_out = (timer_q >= TIMER_LAST);
    end

    always_ff @(posedge gclk_i) begin
        if (res_i) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            din_q   <= '0;
            start_q <= 1'b0;
            timer_q <= '0;
            retry_q <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|req_i && can_tx_ready_i) begin
                        state_q <= S_ARB;
                        busy_q  <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (win_valid) begin
                        din_q   <= win_frame;
                        grant_q <= win_onehot;
                        retry_q <= '0;
                        timer_q <= '0;
                        start_q <= 1'b1;
                        state_q <= S_START;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_START: begin
                    timer_q <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    if (state_q == S_WAIT_BUSY && !can_tx_ready_i) begin
                        timer_q <= timer_d;
                        state_q <= S_WAIT_DONE;
                    end else if (state_q == S_WAIT_DONE && can_tx_ready_i) begin
                        done_q  <= grant_q;
                        state_q <= S_FINISH;
                    end else if (timed_out) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + RW'(1);
                            state_q <= S_RETRY;
                        end else begin
                            err_q   <= grant_q;
                            state_q <= S_FINISH;
                        end
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                // Grant is kept while waiting for the controller to come back.
                S_RETRY: begin
                    if (can_tx_ready_i) begin
                        timer_q <= '0;
                        start_q <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_FINISH: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_o        = grant_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign busy_o         = busy_q;
    assign can_din_o      = din_q;
    assign can_tx_start_o = start_q;

endmodule

// File: tb/tb_can_tx_arbiter.sv
// tb/tb_can_tx_arbiter.sv - randomized self-checking bench for can_tx_arbiter
module tb_can_tx_arbiter;

    localparam int N      = 4;
    localparam int FW     = 108;
    localparam int ID_MSB = 107;
    localparam int TO     = 128;
    localparam int MR     = 2;

    logic            gclk = 1'b0;
    logic            res;
    logic [N-1:0]    req;
    logic [FW-1:0]   frames [N];
    logic [N*FW-1:0] req_frame;
    logic [N-1:0]    grant, done, err;
    logic            busy, can_tx_start, ready;
    logic [FW-1:0]   can_din;

    always #5 gclk = ~gclk;

    always_comb begin
        req_frame = '0;
        for (int i = 0; i < N; i++) req_frame[i*FW +: FW] = frames[i];
    end

    can_tx_arbiter #(.N(N), .FW(FW), .ID_MSB(ID_MSB), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .gclk_i(gclk), .res_i(res), .req_i(req), .req_frame_i(req_frame),
        .grant_o(grant), .done_o(done), .err_o(err), .busy_o(busy),
        .can_din_o(can_din), .can_tx_start_o(can_tx_start), .can_tx_ready_i(ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference model: a transaction advances by elapsed cycles since its start pulse.
    logic [N-1:0]  e_grant = '0, e_done = '0, e_err = '0;
    logic          e_busy = 1'b0, e_start = 1'b0;
    logic [FW-1:0] e_din = '0;
    int  m_owner = -1, m_start_cyc = 0, m_retries = 0, cyc = 0, w;
    bit  m_arb = 0, m_finish = 0, m_hold = 0, m_seen_low = 0;

    always @(posedge gclk) begin
        if (res) begin
            e_grant = '0; e_done = '0; e_err = '0; e_busy = 0; e_start = 0; e_din = '0;
            m_owner = -1; m_arb = 0; m_finish = 0; m_hold = 0; m_seen_low = 0;
        end else begin
            e_start = 0; e_done = '0; e_err = '0;
            if (m_finish) begin
                m_finish = 0; e_grant = '0; e_busy = 0; m_owner = -1;
            end else if (m_arb) begin
                m_arb = 0;
                w = -1;
                for (int i = 0; i < N; i++)
                    if (req[i] && (w < 0 || frames[i][ID_MSB -: 11] < frames[w][ID_MSB -: 11])) w = i;
                if (w < 0) e_busy = 0;
                else begin
                    m_owner = w; e_grant = N'(1) << w; e_din = frames[w]; m_retries = 0;
                    e_start = 1; m_start_cyc = cyc + 1; m_seen_low = 0; m_hold = 0;
                end
            end else if (m_owner < 0) begin
                if (|req && ready) begin m_arb = 1; e_busy = 1; end
            end else if (cyc == m_start_cyc) begin
                m_seen_low = 0;
            end else if (m_hold) begin
                if (ready) begin e_start = 1; m_start_cyc = cyc + 1; m_hold = 0; m_seen_low = 0; end
            end else if (!m_seen_low && !ready) begin
                m_seen_low = 1;
            end else if (m_seen_low && ready) begin
                e_done = e_grant; m_finish = 1;
            end else if (cyc - m_start_cyc >= TO) begin
                if (m_retries < MR) begin m_retries++; m_hold = 1; end
                else begin e_err = e_grant; m_finish = 1; end
            end
        end
        cyc++;
    end

    // Controller model and observation counters.
    int ign = 0, lat = 20, low_left = 0, starts = 0, done_cnt = 0, err_cnt = 0;
    bit rand_ctrl = 0;
    logic [N-1:0] err_seen;
    logic [N-1:0] grant_log [$];

    task automatic tick();
        @(negedge gclk);
        check("grant", FW'(grant), FW'(e_grant));
        check("done", FW'(done), FW'(e_done));
        check("err", FW'(err), FW'(e_err));
        check("busy", FW'(busy), FW'(e_busy));
        check("tx_start", FW'(can_tx_start), FW'(e_start));
        check("can_din", can_din, e_din);
        if (can_tx_start === 1'b1) begin starts++; grant_log.push_back(grant); end
        done_cnt += $countones(done);
        err_cnt  += $countones(err);
        err_seen |= err;
        for (int i = 0; i < N; i++) if (e_done[i] || e_err[i]) req[i] = 1'b0;
        if (e_start) begin
            if (rand_ctrl) begin
                if ($urandom_range(0, 4) == 0) ign = 1;
                lat = $urandom_range(3, 60);
            end
            if (ign > 0) ign--;
            else low_left = lat;
        end
        ready = (low_left == 0);
        if (low_left > 0) low_left--;
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int k;
        k = 0;
        while ((req != '0 || e_busy) && k < budget) begin tick(); k++; end
        n_checks++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic clear_stats();
        starts = 0; done_cnt = 0; err_cnt = 0; err_seen = '0;
        grant_log.delete();
    endtask

    function automatic logic [FW-1:0] make_frame(input logic [10:0] id);
        logic [FW-1:0] f;
        for (int k = 0; k < FW; k++) f[k] = 1'($urandom_range(0, 1));
        f[ID_MSB -: 11] = id;
        return f;
    endfunction

    initial begin
        int k;
        res = 1'b1; req = '0; ready = 1'b1; err_seen = '0;
        for (int i = 0; i < N; i++) frames[i] = '0;
        tick(); tick();
        res = 1'b0;
        check("rst_grant", FW'(grant), FW'(0));
        check("rst_busy", FW'(busy), FW'(0));
        check("rst_din", can_din, '0);
        check("rst_start", FW'(can_tx_start), FW'(0));

        // 1: single request, 3rd-edge start, one done pulse
        clear_stats(); lat = 100;
        frames[0] = make_frame(11'h123); req = 4'b0001;
        tick();
        check("t1_start_edge2", FW'(can_tx_start), FW'(0));
        tick();
        check("t1_start_edge3", FW'(can_tx_start), FW'(1));
        check("t1_din", can_din, frames[0]);
        k = 0;
        while (done === '0 && k < 300) begin tick(); k++; end
        check("t1_done", FW'(done), FW'(4'b0001));
        tick();
        check("t1_busy_after", FW'(busy), FW'(0));
        wait_quiet(50, "t1_quiet");
        check("t1_done_cnt", FW'(done_cnt), FW'(1));

        // 2: priority by lowest ID
        clear_stats(); lat = 20;
        frames[1] = make_frame(11'h300); frames[3] = make_frame(11'h050); req = 4'b1010;
        wait_quiet(600, "t2_quiet");
        check("t2_nstart", FW'(grant_log.size()), FW'(2));
        if (grant_log.size() == 2) begin
            check("t2_first", FW'(grant_log[0]), FW'(4'b1000));
            check("t2_second", FW'(grant_log[1]), FW'(4'b0010));
        end
        check("t2_done_cnt", FW'(done_cnt), FW'(2));

        // 3: ID tie resolved by lowest index
        clear_stats();
        frames[1] = make_frame(11'h200); frames[2] = make_frame(11'h200); req = 4'b0110;
        wait_quiet(600, "t3_quiet");
        check("t3_nstart", FW'(grant_log.size()), FW'(2));
        if (grant_log.size() == 2) begin
            check("t3_first", FW'(grant_log[0]), FW'(4'b0010));
            check("t3_second", FW'(grant_log[1]), FW'(4'b0100));
        end

        // 4: controller ignores every start -> 3 attempts then err
        clear_stats(); ign = 100;
        frames[2] = make_frame(11'h0AA); req = 4'b0100;
        wait_quiet(1000, "t4_quiet");
        check("t4_starts", FW'(starts), FW'(3));
        check("t4_err_cnt", FW'(err_cnt), FW'(1));
        check("t4_err_idx", FW'(err_seen), FW'(4'b0100));
        check("t4_done_cnt", FW'(done_cnt), FW'(0));
        ign = 0;

        // 5: first attempt times out, retry succeeds
        clear_stats(); ign = 1; lat = 30;
        frames[0] = make_frame(11'h010); req = 4'b0001;
        wait_quiet(800, "t5_quiet");
        check("t5_starts", FW'(starts), FW'(2));
        check("t5_done_cnt", FW'(done_cnt), FW'(1));
        check("t5_err_cnt", FW'(err_cnt), FW'(0));

        // 6: reset while the controller is busy
        clear_stats(); lat = 100;
        frames[0] = make_frame(11'h123); req = 4'b0001;
        for (int j = 0; j < 25; j++) tick();
        res = 1'b1; req = '0;
        tick();
        res = 1'b0;
        check("t6_grant", FW'(grant), FW'(0));
        check("t6_busy", FW'(busy), FW'(0));
        check("t6_start", FW'(can_tx_start), FW'(0));
        check("t6_din", can_din, '0);
        check("t6_pulses", FW'({done, err}), FW'(0));
        frames[1] = make_frame(11'h321); req = 4'b0010; lat = 20;
        wait_quiet(600, "t6_quiet");
        check("t6_done_cnt", FW'(done_cnt), FW'(1));
        check("t6_err_cnt", FW'(err_cnt), FW'(0));

        // Random traffic against the model
        rand_ctrl = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 15) == 0) begin
                    if ($urandom_range(0, 1) == 1) frames[i] = make_frame(11'($urandom_range(0, 3) << 8));
                    else frames[i] = make_frame(11'($urandom_range(0, 2047)));
                    req[i] = 1'b1;
                end
        end
        rand_ctrl = 0; lat = 10; ign = 0;
        wait_quiet(5000, "rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
